// File: rtl/bram_dp_param_pkg.sv
// -----------------------------------------------------------------------------
// bram_dp_param_pkg
// Shared constants for the parametrised dual-port block RAM:
//   RDW_READ_OLD    - a read that hits the word being written returns the
//                     pre-write contents.
//   RDW_WRITE_FIRST - a read that hits the word being written returns the
//                     written lanes from di and the unwritten lanes from the
//                     array.
//   num_lanes()     - number of byte-lane write enables for a given data and
//                     lane width.
// -----------------------------------------------------------------------------
package bram_dp_param_pkg;

    localparam int RDW_READ_OLD    = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Number of independently writable lanes in one data word.
    function automatic int num_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage : bram_dp_param_pkg

// File: rtl/bram_dp_param_rd_pipe.sv
// -----------------------------------------------------------------------------
// bram_rd_pipe
// Read-data pipeline for one RAM read port. Registers the raw array/bypass
// word when a read is accepted and produces a one-cycle valid strobe
// RD_LATENCY cycles later. With RD_LATENCY = 2 an extra output register stage
// is added. Data outputs hold their last value between reads. Reset clears
// every stage, so a read in flight when reset asserts never produces a valid.
//
// Ports
//   clk      in   1        clock, all logic on posedge
//   reset    in   1        synchronous, active-high; flushes all stages
//   rd_i     in   1        read accepted on this edge
//   data_i   in   DATA_W   raw word (array read or bypass merge)
//   data_o   out  DATA_W   registered read data
//   valid_o  out  1        data_o belongs to a read issued RD_LATENCY ago
// -----------------------------------------------------------------------------
module bram_rd_pipe #(
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] s1_data_q;
    logic              s1_vld_q;

    // First register stage: capture the word only when a read is accepted so
    // the output holds its last value while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q <= {DATA_W{1'b0}};
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= rd_i;
            if (rd_i) begin
                s1_data_q <= data_i;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_vld_q;

            // Optional output register stage, loaded only behind a valid word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_data_q <= {DATA_W{1'b0}};
                    s2_vld_q  <= 1'b0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign data_o  = s2_data_q;
            assign valid_o = s2_vld_q;
        end else begin : g_lat1
            assign data_o  = s1_data_q;
            assign valid_o = s1_vld_q;
        end
    endgenerate

endmodule : bram_rd_pipe

// File: rtl/bram_dp_param.sv
// -----------------------------------------------------------------------------
// bram_dp_param
// Parametrised dual-port block RAM used as sample/command storage between the
// host FIFO logic and the converter datapaths. Port A reads and writes with
// byte-lane write enables; port B is read-only. Each read port has its own
// read enable, a configurable read latency (1 or 2) and a valid strobe.
// Read-during-write on the same address follows RDW_MODE (READ_OLD or
// WRITE_FIRST lane merge). A registered collision flag reports a port B read
// that hit the address port A was writing in the same cycle.
//
// Ports
//   clk        in   1          single clock, posedge
//   reset      in   1          synchronous active-high; clears outputs and
//                              pipelines, blocks writes, keeps array contents
//   we         in   NUM_LANES  port A lane write enables
//   re_a       in   1          port A read enable
//   a          in   ADDR_W     port A address
//   di         in   DATA_W     port A write data
//   spo        out  DATA_W     port A read data
//   spo_valid  out  1          spo valid strobe
//   re_b       in   1          port B read enable
//   dpra       in   ADDR_W     port B address
//   dpo        out  DATA_W     port B read data
//   dpo_valid  out  1          dpo valid strobe
//   collision  out  1          port B read hit port A write address
//                              (aligned with dpo_valid)
// -----------------------------------------------------------------------------
module bram_dp_param
    import bram_dp_param_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANE_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W/LANE_W-1:0] we,
    input  logic                     re_a,
    input  logic [ADDR_W-1:0]        a,
    input  logic [DATA_W-1:0]        di,
    output logic [DATA_W-1:0]        spo,
    output logic                     spo_valid,
    input  logic                     re_b,
    input  logic [ADDR_W-1:0]        dpra,
    output logic [DATA_W-1:0]        dpo,
    output logic                     dpo_valid,
    output logic                     collision
);

    localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);
    localparam int DEPTH     = 2 ** ADDR_W;

    // Elaboration-time parameter sanity checks.
    generate
        if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
            $error("bram_dp_param: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_W % LANE_W) != 0) begin : g_bad_lanes
            $error("bram_dp_param: DATA_W must be a multiple of LANE_W");
        end
        if ((RDW_MODE != RDW_READ_OLD) && (RDW_MODE != RDW_WRITE_FIRST)) begin : g_bad_rdw
            $error("bram_dp_param: RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en_s;
    logic              hit_b_s;
    logic [DATA_W-1:0] old_a_s;
    logic [DATA_W-1:0] old_b_s;
    logic [DATA_W-1:0] merged_a_s;
    logic [DATA_W-1:0] merged_b_s;
    logic [DATA_W-1:0] raw_a_s;
    logic [DATA_W-1:0] raw_b_s;
    logic              coll1_q;

    // Writes presented while reset is high are dropped.
    assign wr_en_s = (|we) && !reset;
    // Port B hits the word port A is writing this cycle.
    assign hit_b_s = wr_en_s && (dpra == a);

    // Lane-masked array write; unwritten lanes keep their contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we[i]) begin
                    mem_q[a][i*LANE_W +: LANE_W] <= di[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Pre-write contents at both read addresses.
    assign old_a_s = mem_q[a];
    assign old_b_s = mem_q[dpra];

    // Write-first bypass words: written lanes from di, the rest from the array.
    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign merged_a_s[l*LANE_W +: LANE_W] = we[l] ? di[l*LANE_W +: LANE_W]
                                                          : old_a_s[l*LANE_W +: LANE_W];
            assign merged_b_s[l*LANE_W +: LANE_W] = we[l] ? di[l*LANE_W +: LANE_W]
                                                          : old_b_s[l*LANE_W +: LANE_W];
        end
    endgenerate

    // Read-during-write selection: the pipeline samples either the pre-write
    // word or the lane-merged bypass word.
    always_comb begin
        raw_a_s = old_a_s;
        raw_b_s = old_b_s;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (wr_en_s) begin
                raw_a_s = merged_a_s;
            end else begin
                raw_a_s = old_a_s;
            end
            if (hit_b_s) begin
                raw_b_s = merged_b_s;
            end else begin
                raw_b_s = old_b_s;
            end
        end else begin
            raw_a_s = old_a_s;
            raw_b_s = old_b_s;
        end
    end

    bram_rd_pipe #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_a (
        .clk     (clk),
        .reset   (reset),
        .rd_i    (re_a),
        .data_i  (raw_a_s),
        .data_o  (spo),
        .valid_o (spo_valid)
    );

    bram_rd_pipe #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_b (
        .clk     (clk),
        .reset   (reset),
        .rd_i    (re_b),
        .data_i  (raw_b_s),
        .data_o  (dpo),
        .valid_o (dpo_valid)
    );

    // Collision flag, first stage; aligned with the port B read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll1_q <= 1'b0;
        end else begin
            coll1_q <= re_b && hit_b_s;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_coll2
            logic coll2_q;

            // Second collision stage keeps the flag aligned with dpo_valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    coll2_q <= 1'b0;
                end else begin
                    coll2_q <= coll1_q;
                end
            end

            assign collision = coll2_q;
        end else begin : g_coll1
            assign collision = coll1_q;
        end
    endgenerate

`ifdef BRAM_TRACE
    // Simulation-only write trace.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            $display("bram_dp_param write a=%0h we=%b di=%h", a, we, di);
        end
    end
`endif

endmodule : bram_dp_param
